tl_cntr_param: RTL
==================

Name: tl_cntr_param

Overview:
- Parametrised traffic-light controller; successor to the fixed two-road, left-turn controller.
- Serves NUM_DIR approaches in round-robin order.
- Per approach: sensor-extended green, yellow, optional left-turn phase, yellow, then all-red clearance.
- Adds a maintenance flash mode; every phase duration is counter-timed from a parameter.

Parameters:
- NUM_DIR, 2, number of approaches (2..8).
- CNT_W, 8, phase timer width; every duration below must be < 2^CNT_W.
- GREEN_MIN, 4, minimum green cycles (>=1).
- GREEN_MAX, 10, maximum green cycles (>=GREEN_MIN).
- YELLOW_T, 2, yellow cycles (>=1).
- LEFT_T, 3, left-turn cycles (>=1).
- ALLRED_T, 1, all-red clearance cycles (>=1).
- FLASH_T, 4, flash half-period in cycles (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- t_sens  input  NUM_DIR  bit i=1: traffic waiting/present on approach i.
- left_req  input  NUM_DIR  bit i=1: left-turn request on approach i; may be a 1-cycle pulse.
- flash  input  1  level; 1 = maintenance flash mode.
- lights  output  2*NUM_DIR  approach i uses bits [2i+1:2i]: 00 green, 01 yellow, 10 left-turn, 11 red.
- cur_dir  output  clog2(NUM_DIR) (min 1)  approach currently served.
- phase  output  3  state code: GREEN=0, YEL1=1, LEFT=2, YEL2=3, ALLRED=4, FLASH=5.

Behaviour:
- Moore machine; all outputs decode from registers and change only on the clock edge (or on reset).
- Reset (asynchronous, any time, including mid-phase):
  - state GREEN, cur_dir=0, timer=0, left latches=0, blink=0.
  - lights: approach 0 = 00, all others = 11.
- Timer: 0 in the first cycle of every state; increments each cycle in that state. A fixed state of duration D exits on the edge where timer==D-1, so it lasts exactly D cycles.
- GREEN:
  - Exits when timer>=GREEN_MIN-1 AND (t_sens[cur_dir]==0 OR timer==GREEN_MAX-1). Green lasts GREEN_MIN..GREEN_MAX cycles.
  - Next state: YEL1.
- YEL1: YELLOW_T cycles, then:
  - LEFT if (left_lat[cur_dir] | left_req[cur_dir]) at the exit edge;
  - otherwise ALLRED.
- LEFT: LEFT_T cycles, then YEL2.
- YEL2: YELLOW_T cycles, then ALLRED.
- ALLRED: ALLRED_T cycles, then GREEN with cur_dir = cur_dir+1, wrapping NUM_DIR-1 to 0.
- Lights outside FLASH:
  - served approach: GREEN 00, YEL1/YEL2 01, LEFT 10, ALLRED 11;
  - every other approach: always 11.
  - Two approaches are never non-red at the same time.
- Left latches: left_lat[i] is set on any edge where left_req[i]=1. It is cleared on the edge that enters LEFT for approach i; clear wins over a coincident set.
- FLASH:
  - flash=1 sampled on any edge forces the next state to FLASH from any state; it has priority over all other transitions.
  - On entry: timer=0, blink=0. All approaches show 01 while blink=0 and 11 while blink=1. blink toggles every FLASH_T cycles.
  - cur_dir is held. All left latches are cleared while in FLASH.
  - flash=0 sampled while in FLASH: next state ALLRED (full ALLRED_T), then GREEN of approach 0.
- Sensors and left requests are ignored for approaches not currently served, except for left-latch capture.

Test Plan:
- Reset, then t_sens=0, left_req=0 (defaults): lights=4'b1100.
  - Approach 0 green 4 cycles, 01 for 2, 11 for 1.
  - Approach 1 green (lights=4'b0011, cur_dir=1) at cycle 7.
- t_sens[0]=1 held: approach 0 green for exactly 10 cycles (GREEN_MAX).
  - Drop t_sens[0] at cycle 6: green ends after cycle 6.
- 1-cycle left_req[0] pulse at cycle 1 of green: phase sequence 0(4),1(2),2(3) with lights[1:0]=10, 3(2),4(1).
  - cur_dir=1 at cycle 12; left_lat[0]=0 afterward.
- NUM_DIR=3, no traffic: cur_dir sequence 0,1,2,0 at 7-cycle spacing; wrap back to 0 verified.
- flash=1 during LEFT: next cycle phase=5, all lights 01 for 4 cycles, then 11 for 4, alternating.
  - Release flash: 1 ALLRED cycle, then GREEN with cur_dir=0; pending left latches are gone.
- Assert reset asynchronously mid-YEL2 (between edges): outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the normal sequence restarts at approach 0 green.

Source files
------------

// File: rtl/tl_cntr_param.sv
// Round-robin traffic-light controller for NUM_DIR approaches: sensor-extended green,
// yellow, optional left turn, all-red clearance, plus a maintenance flash mode.
module tl_cntr_param #(
    parameter int unsigned NUM_DIR   = 2,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned LEFT_T    = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned FLASH_T   = 4,
    localparam int unsigned DIR_W    = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DIR-1:0]   t_sens,
    input  logic [NUM_DIR-1:0]   left_req,
    input  logic                 flash,
    output logic [2*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     cur_dir,
    output logic [2:0]           phase
);

    typedef enum logic [2:0] {
        GREEN  = 3'd0,
        YEL1   = 3'd1,
        LEFT   = 3'd2,
        YEL2   = 3'd3,
        ALLRED = 3'd4,
        FLASH  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LEFT_M1   = CNT_W'(LEFT_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_M1  = CNT_W'(FLASH_T - 1);
    localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIR - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [NUM_DIR-1:0] left_lat_q, left_lat_d;
    logic               blink_q, blink_d;
    logic               from_flash_q, from_flash_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= GREEN;
            timer_q      <= '0;
            dir_q        <= '0;
            left_lat_q   <= '0;
            blink_q      <= 1'b0;
            from_flash_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dir_q        <= dir_d;
            left_lat_q   <= left_lat_d;
            blink_q      <= blink_d;
            from_flash_q <= from_flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flash) begin
            state_d = FLASH;
        end else begin
            unique case (state_q)
                GREEN:  if (timer_q >= GMIN_M1 && (!t_sens[dir_q] || timer_q == GMAX_M1))
                            state_d = YEL1;
                YEL1:   if (timer_q == YEL_M1)
                            state_d = (left_lat_q[dir_q] | left_req[dir_q]) ? LEFT : ALLRED;
                LEFT:   if (timer_q == LEFT_M1) state_d = YEL2;
                YEL2:   if (timer_q == YEL_M1) state_d = ALLRED;
                ALLRED: if (timer_q == ALLRED_M1) state_d = GREEN;
                FLASH:  state_d = ALLRED;
                default: state_d = GREEN;
            endcase
        end
    end

    // Leaving flash restarts service at approach 0 once the clearance interval completes.
    always_comb begin
        dir_d        = dir_q;
        from_flash_d = 1'b0;
        if (state_q == FLASH)
            from_flash_d = 1'b1;
        else if (state_q == ALLRED)
            from_flash_d = from_flash_q;
        if (state_q == ALLRED && state_d == GREEN)
            dir_d = from_flash_q ? '0 : ((dir_q == DIR_LAST) ? '0 : dir_q + 1'b1);
    end

    always_comb begin
        left_lat_d = left_lat_q | left_req;
        if (state_d == LEFT && state_q != LEFT)
            left_lat_d[dir_q] = 1'b0;
        if (state_d == FLASH)
            left_lat_d = '0;
    end

    always_comb begin
        timer_d = timer_q + 1'b1;
        blink_d = blink_q;
        if (state_d != state_q) begin
            timer_d = '0;
            blink_d = 1'b0;
        end else if (state_q == FLASH && timer_q == FLASH_M1) begin
            timer_d = '0;
            blink_d = ~blink_q;
        end
    end

    always_comb begin
        lights = '1;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            if (state_q == FLASH) begin
                lights[2*i +: 2] = blink_q ? 2'b11 : 2'b01;
            end else if (DIR_W'(i) == dir_q) begin
                unique case (state_q)
                    GREEN:       lights[2*i +: 2] = 2'b00;
                    YEL1, YEL2:  lights[2*i +: 2] = 2'b01;
                    LEFT:        lights[2*i +: 2] = 2'b10;
                    default:     lights[2*i +: 2] = 2'b11;
                endcase
            end
        end
    end

    assign cur_dir = dir_q;
    assign phase   = state_q;

endmodule
